// File: rtl/rom_scan_ctrl_if.sv
// rtl/rom_scan_ctrl_if.sv - ROM read port and captured-word stream between rom_scan_ctrl and its neighbours
interface rom_scan_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             rom_en;
    logic [DEPTH-1:0] rom_addr;
    logic [DW-1:0]    rom_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_idx;

    modport master (
        output rom_en, rom_addr, out_valid, out_data, out_idx,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_en, rom_addr, out_valid, out_data, out_idx,
        output rom_data, out_ready
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// rtl/rom_scan_ctrl.sv - walks every one-hot ROM address, streams each word out and keeps a checksum
// Optional pattern checker enabled by defining ROM_CHECK_EN.
module rom_scan_ctrl #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic          err,
    rom_scan_ctrl_if.master bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt, idx_inc;
    logic             busy_nxt, done_nxt;
    logic             en_nxt, valid_nxt;
    logic [DEPTH-1:0] addr_nxt;
    logic [DW-1:0]    data_nxt, cks_nxt;
    logic [IW-1:0]    oidx_nxt;

    assign idx_inc = idx + IW'(1);

    // Every output is computed one cycle ahead here and registered below.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        en_nxt    = bus.rom_en;
        addr_nxt  = bus.rom_addr;
        valid_nxt = bus.out_valid;
        data_nxt  = bus.out_data;
        oidx_nxt  = bus.out_idx;
        cks_nxt   = checksum;
        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                en_nxt   = 1'b0;
                addr_nxt = '0;
                if (start) begin
                    idx_nxt   = '0;
                    cks_nxt   = '0;
                    busy_nxt  = 1'b1;
                    en_nxt    = 1'b1;
                    addr_nxt  = DEPTH'(1);
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_CAPT;
            S_CAPT: begin
                data_nxt  = bus.rom_data;
                oidx_nxt  = idx;
                valid_nxt = 1'b1;
                en_nxt    = 1'b0;
                addr_nxt  = '0;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_valid && bus.out_ready) begin
                    valid_nxt = 1'b0;
                    cks_nxt   = checksum + bus.out_data;
                    if (idx == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_inc;
                        en_nxt    = 1'b1;
                        addr_nxt  = DEPTH'(1) << idx_inc;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.rom_en    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            checksum      <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            bus.rom_en    <= en_nxt;
            bus.rom_addr  <= addr_nxt;
            bus.out_valid <= valid_nxt;
            bus.out_data  <= data_nxt;
            bus.out_idx   <= oidx_nxt;
            checksum      <= cks_nxt;
        end
    end

`ifdef ROM_CHECK_EN
    // Reference word for entry idx is the nibble (idx+1) repeated: 0x11, 0x22, ...
    logic [3:0]    nib;
    logic [DW-1:0] ref_pat;
    logic          err_q, err_nxt;

    assign nib     = 4'(idx) + 4'd1;
    assign ref_pat = DW'({nib, nib});

    always_comb begin
        err_nxt = err_q;
        if (state == S_IDLE && start)
            err_nxt = 1'b0;
        else if (state == S_CAPT && bus.rom_data != ref_pat)
            err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_nxt;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb/tb_rom_scan_ctrl.sv - self-checking bench for rom_scan_ctrl with a behavioural ROM and scan model
module tb_rom_scan_ctrl;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef ROM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [DW-1:0] checksum;

    rom_scan_ctrl_if #(.DEPTH(DEPTH), .DW(DW)) ifc ();

    rom_scan_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .err      (err),
        .bus      (ifc.master)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: registered read, data one clock after en/addr are sampled.
    logic [DW-1:0] rom_mem [DEPTH];
    logic [DW-1:0] rom_q;
    assign ifc.rom_data = rom_q;

    function automatic logic [DW-1:0] rom_lookup(input logic [DEPTH-1:0] a);
        if (!$onehot(a)) return 'x;
        for (int i = 0; i < DEPTH; i++)
            if (a[i]) return rom_mem[i];
        return 'x;
    endfunction

    always @(posedge clk)
        if (ifc.rom_en) rom_q <= rom_lookup(ifc.rom_addr);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int i);
        return DW'((i + 1) * 8'h11);
    endfunction

    function automatic logic exp_err_upto(input int k);
        if (!CHECK_EN) return 1'b0;
        for (int i = 0; i <= k && i < DEPTH; i++)
            if (rom_mem[i] !== pattern(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_sum();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(rom_mem[i]);
        return DW'(s);
    endfunction

    logic [DW-1:0]    got_d [$];
    int               got_i [$];
    logic [DEPTH-1:0] addr_seq [$];
    int               done_n, first_valid_n;

    // Runs one scan from IDLE; called and returns at a negedge.
    task automatic run_scan(input int ready_pct, input bit hold_start, input int mid_start_n);
        int n;
        bit fin, prev_en;
        got_d.delete(); got_i.delete(); addr_seq.delete();
        done_n = -1; first_valid_n = -1;
        start = 1'b1;
        @(negedge clk);
        start = hold_start;
        n = 0; fin = 1'b0; prev_en = 1'b0;
        while (!fin && n < 400) begin
            if (n == mid_start_n) start = 1'b1;
            else if (n == mid_start_n + 1) start = hold_start;
            if (ifc.rom_en && !prev_en) addr_seq.push_back(ifc.rom_addr);
            prev_en = ifc.rom_en;
            if (ifc.out_valid) begin
                if (first_valid_n < 0) first_valid_n = n;
                chk("err_track", err, exp_err_upto(int'(ifc.out_idx)));
            end
            ifc.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (ifc.out_valid && ifc.out_ready) begin
                got_d.push_back(ifc.out_data);
                got_i.push_back(int'(ifc.out_idx));
            end
            if (done) begin
                done_n = n;
                fin = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        if (!fin) chk("scan_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_scan();
        chk("word_count", got_d.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < got_d.size(); k++) begin
            chk($sformatf("word%0d_idx", k), got_i[k], k);
            chk($sformatf("word%0d_data", k), got_d[k], rom_mem[k]);
        end
        chk("addr_count", addr_seq.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < addr_seq.size(); k++)
            chk($sformatf("addr%0d", k), addr_seq[k], 32'd1 << k);
        chk("scan_checksum", checksum, exp_sum());
        chk("scan_err", err, exp_err_upto(DEPTH - 1));
        chk("done_single", done, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    task automatic wait_word(input int idx, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (ifc.out_valid && int'(ifc.out_idx) == idx) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk($sformatf("wait_word%0d_timeout", idx), 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        if (!seen) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = pattern(i);
        ifc.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rom_en", ifc.rom_en, 1'b0);
        chk("rst_rom_addr", ifc.rom_addr, 32'd0);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_out_idx", ifc.out_idx, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_rom_en", ifc.rom_en, 1'b0);
            chk("idle_rom_addr", ifc.rom_addr, 32'd0);
        end

        // Full scan, consumer always ready
        run_scan(100, 1'b0, -1);
        chk("first_valid_latency", first_valid_n, 32'd2);
        chk("done_cycle", done_n, 32'd24);
        check_scan();
        chk("full_checksum", checksum, 32'h64);
        repeat (3) @(negedge clk);
        chk("checksum_hold_idle", checksum, 32'h64);

        // Backpressure on idx 3
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ifc.out_ready = 1'b1;
        wait_word(3, seen);
        ifc.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", ifc.out_valid, 1'b1);
            chk("bp_data", ifc.out_data, 32'h44);
            chk("bp_idx", ifc.out_idx, 32'd3);
            chk("bp_rom_en", ifc.rom_en, 1'b0);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_en", ifc.rom_en, 1'b1);
        chk("bp_next_addr", ifc.rom_addr, 32'h10);
        chk("bp_next_valid", ifc.out_valid, 1'b0);
        wait_done();
        chk("bp_checksum", checksum, 32'h64);

        // Start mid-scan is ignored; start held high re-triggers after done
        run_scan(100, 1'b1, 10);
        chk("mid_start_done_cycle", done_n, 32'd24);
        check_scan();
        chk("hold_idle_checksum", checksum, 32'h64);
        @(negedge clk);
        chk("restart_busy", busy, 1'b1);
        chk("restart_checksum_clear", checksum, 32'd0);
        chk("restart_rom_en", ifc.rom_en, 1'b1);
        chk("restart_rom_addr", ifc.rom_addr, 32'h01);
        start = 1'b0;
        ifc.out_ready = 1'b1;
        wait_done();
        chk("restart_checksum", checksum, 32'h64);

        // Asynchronous reset while holding idx 4
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_word(4, seen);
        ifc.out_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ifc.out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rom_en", ifc.rom_en, 1'b0);
        chk("arst_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(100, 1'b0, -1);
        check_scan();

        // Corrupted entry 5
        rom_mem[5] = '0;
        run_scan(60, 1'b0, -1);
        check_scan();
        chk("corrupt_checksum", checksum, 32'hFE);
        chk("corrupt_err", err, CHECK_EN);

        // Randomized ROM contents and consumer stalls
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++)
                rom_mem[i] = ($urandom_range(0, 1) != 0) ? pattern(i) : DW'($urandom);
            run_scan(int'($urandom_range(25, 100)), 1'b0, -1);
            check_scan();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
